csr_resp_slave: RTL and testbench

CSR responder at the DUT end of the CSR-in request channel. Accepts read/write requests over a valid/ready request channel, applies them to a bank of NUM_REGS word-wide control registers, and returns exactly one response per request, with read data and an error flag, over a valid/ready response channel. Register contents drive the design through a flat output bus. This is the counterpart that the CSR-in agent's driver talks to.

---
 rtl/csr_resp_pkg.sv | 37 +++
 rtl/csr_resp_decode.sv | 31 +++
 rtl/csr_resp_slave.sv | 157 +++++++++++++++
 tb/tb_csr_resp_slave.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csr_resp_pkg.sv
// csr_resp_pkg: shared types and defaults for the CSR responder.
//   slot_state_t  - response slot occupancy (EMPTY/FULL)
//   err_cause_t   - request rejection cause, shared with the verification scoreboard
//   DEF_ADDR_W    - default byte-address width
//   DEF_ID_VALUE  - default constant for read-only register 0
//   apply_wstrb() - byte-lane merge of new write data into an old word
package csr_resp_pkg;

    localparam int unsigned DEF_ADDR_W   = 12;
    localparam logic [31:0] DEF_ID_VALUE = 32'hC5A0_0001;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_ALIGN = 2'd1,
        ERR_RANGE = 2'd2,
        ERR_RO    = 2'd3
    } err_cause_t;

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] merged;
        merged = old_word;
        for (int unsigned b = 0; b < 4; b++) begin
            if (strb[b]) begin
                merged[b*8 +: 8] = new_word[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/csr_resp_decode.sv
// csr_resp_decode: combinational address and permission check.
//   addr  in  ADDR_W    byte address of the request
//   write in  1         1 = write request
//   idx   out ADDR_W-2  word index (addr[ADDR_W-1:2])
//   err   out enum      rejection cause; misalignment wins over range,
//                       range wins over a write to read-only register 0
module csr_resp_decode
    import csr_resp_pkg::*;
#(
    parameter int unsigned ADDR_W   = DEF_ADDR_W,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              write,
    output logic [ADDR_W-3:0] idx,
    output err_cause_t        err
);

    always_comb begin
        idx = addr[ADDR_W-1:2];
        err = ERR_NONE;
        if (addr[1:0] != 2'b00) begin
            err = ERR_ALIGN;
        end else if (32'(idx) >= NUM_REGS) begin
            err = ERR_RANGE;
        end else if (write && (idx == '0)) begin
            err = ERR_RO;
        end
    end

endmodule

// File: rtl/csr_resp_slave.sv
// csr_resp_slave: CSR responder with a bank of NUM_REGS word registers.
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake; req_ready = !rsp_valid || rsp_ready
//   req_write/addr/wdata/wstrb  request fields
//   rsp_valid/rsp_ready    response handshake (single-entry response slot)
//   rsp_rdata/rsp_err      read data (0 for writes and errors), error flag
//   reg_q                  flat register contents; slot 0 is the constant ID_VALUE
// Configuration macro: CSR_RESP_WSTRB_EN - when defined, req_wstrb selects the
// byte lanes a write updates; otherwise every valid write replaces the full word.
module csr_resp_slave
    import csr_resp_pkg::*;
#(
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       NUM_REGS = 16,
    parameter logic [DATA_W-1:0] ID_VALUE = DEF_ID_VALUE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       req_write,
    input  logic [ADDR_W-1:0]          req_addr,
    input  logic [DATA_W-1:0]          req_wdata,
    input  logic [DATA_W/8-1:0]        req_wstrb,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [DATA_W-1:0]          rsp_rdata,
    output logic                       rsp_err,
    output logic [NUM_REGS*DATA_W-1:0] reg_q
);

    localparam int unsigned IDX_W = ADDR_W - 2;

    logic [IDX_W-1:0]  idx;
    err_cause_t        err_cause;
    logic              accept;
    logic              wr_en;
    logic [DATA_W-1:0] rd_word;
    logic [DATA_W-1:0] wr_word;
    slot_state_t       state_q;
    slot_state_t       state_d;
    logic              rsp_load;
    logic [DATA_W-1:0] rsp_rdata_q;
    logic              rsp_err_q;

    // Register 0 is a constant, so storage exists only for 1..NUM_REGS-1.
    logic [DATA_W-1:0] regs [1:NUM_REGS-1];

    csr_resp_decode #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_decode (
        .addr  (req_addr),
        .write (req_write),
        .idx   (idx),
        .err   (err_cause)
    );

    assign rsp_valid = (state_q == FULL);
    assign req_ready = !rsp_valid || rsp_ready;
    assign accept    = req_valid && req_ready;
    assign wr_en     = accept && req_write && (err_cause == ERR_NONE);
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

    // Response slot occupancy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // An accept while FULL is only possible when rsp_ready is high, so the
    // slot reloads in place instead of passing through EMPTY.
    always_comb begin
        state_d  = state_q;
        rsp_load = 1'b0;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    state_d  = FULL;
                    rsp_load = 1'b1;
                end
            end
            FULL: begin
                if (accept) begin
                    rsp_load = 1'b1;
                end else if (rsp_ready) begin
                    state_d = EMPTY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Read mux: defaults to ID_VALUE, which covers idx 0; out-of-range
    // indices are masked by the error path.
    always_comb begin
        rd_word = ID_VALUE;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            if (idx == IDX_W'(i)) begin
                rd_word = regs[i];
            end
        end
    end

`ifdef CSR_RESP_WSTRB_EN
    always_comb begin
        wr_word = apply_wstrb(rd_word, req_wdata, req_wstrb);
    end
`else
    logic unused_wstrb;
    assign unused_wstrb = ^req_wstrb;

    always_comb begin
        wr_word = req_wdata;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else if (rsp_load) begin
            rsp_err_q   <= (err_cause != ERR_NONE);
            rsp_rdata_q <= ((err_cause != ERR_NONE) || req_write) ? '0 : rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr_en) begin
            for (int unsigned i = 1; i < NUM_REGS; i++) begin
                if (idx == IDX_W'(i)) begin
                    regs[i] <= wr_word;
                end
            end
        end
    end

    always_comb begin
        reg_q             = '0;
        reg_q[0 +: DATA_W] = ID_VALUE;
        for (int unsigned i = 1; i < NUM_REGS; i++) begin
            reg_q[i*DATA_W +: DATA_W] = regs[i];
        end
    end

endmodule

// File: tb/tb_csr_resp_slave.sv
// tb_csr_resp_slave: directed bench for csr_resp_slave with a behavioural
// register/response model and per-cycle output comparison.
// Honours CSR_RESP_WSTRB_EN the same way as the design build.
module tb_csr_resp_slave;
    import csr_resp_pkg::*;

    localparam int unsigned ADDR_W   = 12;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned NUM_REGS = 16;
    localparam logic [31:0] ID_VAL   = 32'hC5A0_0001;

    logic                       clk;
    logic                       rst_n;
    logic                       req_valid;
    logic                       req_ready;
    logic                       req_write;
    logic [ADDR_W-1:0]          req_addr;
    logic [DATA_W-1:0]          req_wdata;
    logic [DATA_W/8-1:0]        req_wstrb;
    logic                       rsp_valid;
    logic                       rsp_ready;
    logic [DATA_W-1:0]          rsp_rdata;
    logic                       rsp_err;
    logic [NUM_REGS*DATA_W-1:0] reg_q;

    csr_resp_slave #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ID_VALUE (ID_VAL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .reg_q     (reg_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0] m_regs [NUM_REGS];
    logic        m_valid;
    logic [31:0] m_rdata;
    logic        m_err;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid = 1'b0;
            m_rdata = '0;
            m_err   = 1'b0;
            for (int i = 0; i < NUM_REGS; i++) m_regs[i] = (i == 0) ? ID_VAL : 32'h0;
        end else if (req_valid && (!m_valid || rsp_ready)) begin : model_accept
            int unsigned ix;
            err_cause_t  cause;
            logic [31:0] nw;
            ix    = int'(req_addr) / 4;
            cause = ERR_NONE;
            if (int'(req_addr) % 4 != 0)      cause = ERR_ALIGN;
            else if (ix >= NUM_REGS)          cause = ERR_RANGE;
            else if (req_write && ix == 0)    cause = ERR_RO;
            m_valid = 1'b1;
            m_err   = (cause != ERR_NONE);
            m_rdata = '0;
            if (cause == ERR_NONE) begin
                if (req_write) begin
                    nw = m_regs[ix];
                    for (int b = 0; b < 4; b++) begin
`ifdef CSR_RESP_WSTRB_EN
                        if (req_wstrb[b]) nw[b*8 +: 8] = req_wdata[b*8 +: 8];
`else
                        nw[b*8 +: 8] = req_wdata[b*8 +: 8];
`endif
                    end
                    m_regs[ix] = nw;
                end else begin
                    m_rdata = m_regs[ix];
                end
            end
        end else if (rsp_ready) begin
            m_valid = 1'b0;
        end
    end

    // Compare process: every cycle, on the inactive edge.
    always @(negedge clk) begin
        check("req_ready", {31'h0, req_ready}, {31'h0, (!m_valid || rsp_ready)});
        check("rsp_valid", {31'h0, rsp_valid}, {31'h0, m_valid});
        if (m_valid) begin
            check("rsp_rdata", rsp_rdata, m_rdata);
            check("rsp_err", {31'h0, rsp_err}, {31'h0, m_err});
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            check($sformatf("reg_q[%0d]", i), reg_q[i*32 +: 32], m_regs[i]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic send(input logic w, input logic [11:0] a, input logic [31:0] d,
                        input logic [3:0] s);
        bit done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        req_wstrb = s;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (!m_valid || rsp_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: got no accept expected accept for addr %h", a);
        end
    endtask

    task automatic idle();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 12'h008;
        req_wdata = 32'h1234_5678;
        req_wstrb = 4'hF;
        rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_no_accept_reg2", reg_q[2*32 +: 32], 32'h0);
        check("rst_rsp_rdata", rsp_rdata, 32'h0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_slot0", reg_q[31:0], 32'hC5A0_0001);
        check("rst_req_ready", {31'h0, req_ready}, 32'h1);

        // ID and plain reads
        send(1'b0, 12'h000, 32'h0, 4'h0);
        check("rd_id", rsp_rdata, 32'hC5A0_0001);
        check("rd_id_err", {31'h0, rsp_err}, 32'h0);
        send(1'b0, 12'h004, 32'h0, 4'h0);
        check("rd_reg1", rsp_rdata, 32'h0);
        idle();

        // write then back-to-back read
        send(1'b1, 12'h008, 32'hDEAD_BEEF, 4'hF);
        check("wr_reg2_visible", reg_q[2*32 +: 32], 32'hDEAD_BEEF);
        check("wr_rdata_zero", rsp_rdata, 32'h0);
        send(1'b0, 12'h008, 32'h0, 4'h0);
        check("rd_after_wr", rsp_rdata, 32'hDEAD_BEEF);
        send(1'b1, 12'h00C, 32'h0C0C_0C0C, 4'hF);
        idle();

        // error cases
        send(1'b1, 12'h000, 32'hFFFF_FFFF, 4'hF);
        check("err_ro", {31'h0, rsp_err}, 32'h1);
        check("err_ro_rdata", rsp_rdata, 32'h0);
        send(1'b0, 12'h002, 32'h0, 4'h0);
        check("err_align", {31'h0, rsp_err}, 32'h1);
        check("err_align_rdata", rsp_rdata, 32'h0);
        send(1'b0, 12'h040, 32'h0, 4'h0);
        check("err_range", {31'h0, rsp_err}, 32'h1);
        check("err_range_rdata", rsp_rdata, 32'h0);
        idle();
        check("err_slot0_kept", reg_q[31:0], 32'hC5A0_0001);
        check("err_slot2_kept", reg_q[2*32 +: 32], 32'hDEAD_BEEF);

        // stall with a queued request
        rsp_ready = 1'b0;
        send(1'b0, 12'h008, 32'h0, 4'h0);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 12'h00C;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk);
            #1;
            check("stall_valid", {31'h0, rsp_valid}, 32'h1);
            check("stall_rdata", rsp_rdata, 32'hDEAD_BEEF);
            check("stall_req_ready", {31'h0, req_ready}, 32'h0);
        end
        rsp_ready = 1'b1;
        #1;
        check("release_req_ready", {31'h0, req_ready}, 32'h1);
        @(posedge clk);
        #1;
        check("queued_rdata", rsp_rdata, 32'h0C0C_0C0C);
        check("queued_valid", {31'h0, rsp_valid}, 32'h1);
        idle();

        // streaming writes then reads, one per cycle, in order
        begin
            int t0;
            t0 = cyc;
            for (int i = 0; i < 8; i++) begin
                send(1'b1, 12'((i + 4) * 4), 32'hA500_0000 | 32'(i), 4'hF);
                check("stream_wr_valid", {31'h0, rsp_valid}, 32'h1);
                check("stream_wr_err", {31'h0, rsp_err}, 32'h0);
            end
            check("stream_wr_cycles", 32'(cyc - t0), 32'd8);
            t0 = cyc;
            for (int i = 0; i < 8; i++) begin
                send(1'b0, 12'((i + 4) * 4), 32'h0, 4'h0);
                check("stream_rd_data", rsp_rdata, 32'hA500_0000 | 32'(i));
            end
            check("stream_rd_cycles", 32'(cyc - t0), 32'd8);
        end
        idle();

        // byte strobes
        send(1'b1, 12'h004, 32'h1122_3344, 4'hF);
        send(1'b1, 12'h004, 32'hAABB_CCDD, 4'b0101);
        idle();
`ifdef CSR_RESP_WSTRB_EN
        check("wstrb_merge", reg_q[1*32 +: 32], 32'h11BB_33DD);
        send(1'b1, 12'h004, 32'hFFFF_FFFF, 4'h0);
        check("wstrb_zero_err", {31'h0, rsp_err}, 32'h0);
        idle();
        check("wstrb_zero_keep", reg_q[1*32 +: 32], 32'h11BB_33DD);
`else
        check("wstrb_ignored", reg_q[1*32 +: 32], 32'hAABB_CCDD);
`endif

        // reset with a pending response
        rsp_ready = 1'b0;
        send(1'b0, 12'h008, 32'h0, 4'h0);
        check("pre_reset_valid", {31'h0, rsp_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", {31'h0, rsp_valid}, 32'h0);
        check("midrst_reg2", reg_q[2*32 +: 32], 32'h0);
        check("midrst_rdata", rsp_rdata, 32'h0);
        req_valid = 1'b0;
        @(negedge clk);
        rst_n     = 1'b1;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("post_rst_reg1", reg_q[1*32 +: 32], 32'h0);
        check("post_rst_slot0", reg_q[31:0], 32'hC5A0_0001);
        @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
